// File: rtl/tumble_run_ctrl_pkg.sv
// Shared types for the marble-board run controller: state enum, colour codes, count width.
// Pure declarations, no logic.
package tumble_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      TRIG   = 3'd1,
      RUN    = 3'd2,
      SETTLE = 3'd3,
      DONE   = 3'd4
   } run_state_t;

   localparam logic COLOUR_BLUE = 1'b0;
   localparam logic COLOUR_RED  = 1'b1;

   function automatic int count_w(input int max_balls);
      return $clog2(max_balls + 1);
   endfunction

endpackage

// File: rtl/tumble_run_ctrl_if.sv
// Host/board signal bundle for tumble_run_ctrl; master = harness side, slave = controller side.
// No storage; pulses (go, abort, rel_i) are single-cycle with no handshake.
interface tumble_run_ctrl_if
   import tumble_pkg::*;
#(
   parameter int MAX_BALLS = 16
);
   localparam int CW = count_w(MAX_BALLS);

   logic                 go;
   logic                 abort;
   logic                 trig_o;
   logic                 rel_i;
   logic                 colour_i;
   logic                 stopped_i;
   logic                 busy;
   logic                 done;
   logic                 overflow;
   logic                 timed_out;
   logic                 aborted;
   logic [CW-1:0]        ball_count;
   logic [MAX_BALLS-1:0] trace;

   modport master (
      output go, abort, rel_i, colour_i, stopped_i,
      input  trig_o, busy, done, overflow, timed_out, aborted, ball_count, trace
   );

   modport slave (
      input  go, abort, rel_i, colour_i, stopped_i,
      output trig_o, busy, done, overflow, timed_out, aborted, ball_count, trace
   );

endinterface

// File: rtl/tumble_run_ctrl_trace_buf.sv
// Release trace: writes colour at index ball_count, saturating count, overflow strobe when full.
// Write takes effect next cycle; no backpressure, a release into a full buffer only strobes ovf_stb.
module tumble_trace_buf
   import tumble_pkg::*;
#(
   parameter int MAX_BALLS = 16,
   localparam int CW = count_w(MAX_BALLS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 rec,
   input  logic                 colour,
   output logic                 ovf_stb,
   output logic [CW-1:0]        count,
   output logic [MAX_BALLS-1:0] trace
);

   logic [CW-1:0]        count_q, count_d;
   logic [MAX_BALLS-1:0] trace_q, trace_d;
   logic                 full;

   assign full    = (count_q == CW'(MAX_BALLS));
   assign ovf_stb = rec && full;

   always_comb begin
      count_d = count_q;
      trace_d = trace_q;
      if (clr) begin
         count_d = '0;
         trace_d = '0;
      end else if (rec && !full) begin
         // Loop-decoded write keeps the index compare at the count width.
         for (int k = 0; k < MAX_BALLS; k++) begin
            if (count_q == CW'(k)) trace_d[k] = colour;
         end
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         trace_q <= '0;
      end else begin
         count_q <= count_d;
         trace_q <= trace_d;
      end
   end

   assign count = count_q;
   assign trace = trace_q;

endmodule

// File: rtl/tumble_run_ctrl.sv
// Run sequencer: trig_o one cycle after go, traces releases, ends on settle/overflow/abort; no backpressure.
// Optional watchdog under TUMBLE_WDOG_EN (timed_out tied 0 otherwise).
module tumble_run_ctrl
   import tumble_pkg::*;
#(
   parameter int MAX_BALLS     = 16,
   parameter int SETTLE_CYCLES = 4
`ifdef TUMBLE_WDOG_EN
   ,
   parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input logic              clk,
   input logic              rst,
   tumble_run_ctrl_if.slave bus
);
   localparam int CW = count_w(MAX_BALLS);
   localparam int SW = $clog2(SETTLE_CYCLES + 1);

   run_state_t           state_q, state_d;
   logic [SW-1:0]        settle_q, settle_d;
   logic                 overflow_q, overflow_d;
   logic                 timed_out_q, timed_out_d;
   logic                 aborted_q, aborted_d;
   logic                 trig_q, trig_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 start, in_run, rec, ovf_stb, wdog_exp;
   logic [CW-1:0]        ball_count;
   logic [MAX_BALLS-1:0] trace;

   assign in_run = (state_q == TRIG) || (state_q == RUN) || (state_q == SETTLE);
   assign start  = bus.go && ((state_q == IDLE) || (state_q == DONE));
   assign rec    = in_run && bus.rel_i;

   tumble_trace_buf #(.MAX_BALLS(MAX_BALLS)) u_trace (
      .clk     (clk),
      .rst     (rst),
      .clr     (start),
      .rec     (rec),
      .colour  (bus.colour_i),
      .ovf_stb (ovf_stb),
      .count   (ball_count),
      .trace   (trace)
   );

`ifdef TUMBLE_WDOG_EN
   localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
   logic [WW-1:0] wdog_q, wdog_d;

   // Zero in the TRIG cycle, so expiry lands exactly TIMEOUT_CYCLES after the trigger.
   always_comb begin
      wdog_d = wdog_q;
      if (start)       wdog_d = '0;
      else if (in_run) wdog_d = wdog_q + WW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) wdog_q <= '0;
      else     wdog_q <= wdog_d;
   end

   assign wdog_exp = (wdog_q == WW'(TIMEOUT_CYCLES - 1));
`else
   assign wdog_exp = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      settle_d    = settle_q;
      overflow_d  = overflow_q;
      timed_out_d = timed_out_q;
      aborted_d   = aborted_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d     = TRIG;
               settle_d    = '0;
               overflow_d  = 1'b0;
               timed_out_d = 1'b0;
               aborted_d   = 1'b0;
            end
         end
         TRIG: state_d = RUN;
         RUN: begin
            if (bus.stopped_i && !bus.rel_i) begin
               state_d  = SETTLE;
               settle_d = SW'(1);
            end
         end
         SETTLE: begin
            // A release always reopens the run, even on the cycle the settle would complete.
            if (bus.rel_i)                             state_d = RUN;
            else if (settle_q == SW'(SETTLE_CYCLES)) state_d = DONE;
            else if (!bus.stopped_i)                   state_d = RUN;
            else                                       settle_d = settle_q + SW'(1);
         end
         default: state_d = IDLE;
      endcase

      if (wdog_exp && ((state_q == RUN) || (state_q == SETTLE))) begin
         state_d     = DONE;
         timed_out_d = 1'b1;
      end
      if (ovf_stb) begin
         state_d     = DONE;
         overflow_d  = 1'b1;
         timed_out_d = 1'b0;
      end
      if (in_run && bus.abort) begin
         state_d     = DONE;
         aborted_d   = 1'b1;
         timed_out_d = 1'b0;
      end

      trig_d = (state_d == TRIG);
      busy_d = (state_d == TRIG) || (state_d == RUN) || (state_d == SETTLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         settle_q    <= '0;
         overflow_q  <= 1'b0;
         timed_out_q <= 1'b0;
         aborted_q   <= 1'b0;
         trig_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         settle_q    <= settle_d;
         overflow_q  <= overflow_d;
         timed_out_q <= timed_out_d;
         aborted_q   <= aborted_d;
         trig_q      <= trig_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.trig_o     = trig_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.overflow   = overflow_q;
   assign bus.timed_out  = timed_out_q;
   assign bus.aborted    = aborted_q;
   assign bus.ball_count = ball_count;
   assign bus.trace      = trace;

endmodule

// File: tb/tb_tumble_run_ctrl.sv
// Bench for tumble_run_ctrl: directed scenarios plus randomized runs against a window-rule model.
// Optional watchdog checks under TUMBLE_WDOG_EN.
module tb_tumble_run_ctrl;
   import tumble_pkg::*;

   localparam int MAXB   = 16;
   localparam int SETTLE = 4;
   localparam int CW     = $clog2(MAXB + 1);
   localparam int NMAX   = 200;
`ifdef TUMBLE_WDOG_EN
   localparam int TMO    = 32;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tumble_run_ctrl_if #(.MAX_BALLS(MAXB)) bus ();

   tumble_run_ctrl #(
      .MAX_BALLS     (MAXB),
      .SETTLE_CYCLES (SETTLE)
`ifdef TUMBLE_WDOG_EN
      ,
      .TIMEOUT_CYCLES(TMO)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   bit rel_a [NMAX];
   bit col_a [NMAX];
   bit st_a  [NMAX];
   bit ab_a  [NMAX];

   int             obs_done;
   logic [MAXB-1:0] obs_trace;
   logic [CW-1:0]  obs_cnt;
   logic           obs_ovf, obs_to, obs_ab;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      bus.go = 1'b0; bus.abort = 1'b0; bus.rel_i = 1'b0;
      bus.colour_i = 1'b0; bus.stopped_i = 1'b0;
   endtask

   task automatic clear_arrays;
      for (int i = 0; i < NMAX; i++) begin
         rel_a[i] = 1'b0; col_a[i] = 1'b0; st_a[i] = 1'b0; ab_a[i] = 1'b0;
      end
   endtask

   // Cycle i = 0 is the TRIG cycle; obs_done = i when done is first visible after cycle i's edge.
   task automatic drive_run(input int n);
      obs_done = -1;
      bus.go = 1'b1; step; bus.go = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.rel_i = rel_a[i]; bus.colour_i = col_a[i];
         bus.stopped_i = st_a[i]; bus.abort = ab_a[i];
         step;
         if (bus.done === 1'b1) begin obs_done = i; break; end
      end
      idle_inputs;
      obs_trace = bus.trace; obs_cnt = bus.ball_count;
      obs_ovf = bus.overflow; obs_to = bus.timed_out; obs_ab = bus.aborted;
   endtask

   // Run ends on overflow/abort, on watchdog, or once SETTLE quiet stopped cycles are followed by a release-free cycle.
   function automatic void model_run(input int n, output int e, output logic [MAXB-1:0] tr,
                                     output int cnt, output bit ovf, output bit ab, output bit to);
      bit quiet;
      e = -1; tr = '0; cnt = 0; ovf = 1'b0; ab = 1'b0; to = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (rel_a[i]) begin
            if (cnt < MAXB) begin tr[cnt] = col_a[i]; cnt++; end
            else ovf = 1'b1;
         end
         if (ab_a[i]) ab = 1'b1;
         if (ovf || ab) begin e = i; return; end
`ifdef TUMBLE_WDOG_EN
         if (i == TMO - 1) begin to = 1'b1; e = i; return; end
`endif
         if (i >= SETTLE + 1 && !rel_a[i]) begin
            quiet = 1'b1;
            for (int j = i - SETTLE; j < i; j++) if (!st_a[j] || rel_a[j]) quiet = 1'b0;
            if (quiet) begin e = i; return; end
         end
      end
   endfunction

   task automatic test_reset;
      idle_inputs;
      rst = 1'b1; step; step;
      n_cmp++; if ({bus.trig_o, bus.busy, bus.done} !== 3'b000) begin n_fail++;
         $display("FAIL reset_ctl: got %b expected 000", {bus.trig_o, bus.busy, bus.done}); end
      n_cmp++; if ({bus.overflow, bus.timed_out, bus.aborted} !== 3'b000) begin n_fail++;
         $display("FAIL reset_flags: got %b expected 000", {bus.overflow, bus.timed_out, bus.aborted}); end
      n_cmp++; if (bus.ball_count !== '0 || bus.trace !== '0) begin n_fail++;
         $display("FAIL reset_trace: got cnt %0d trace %h expected 0 0", bus.ball_count, bus.trace); end
      rst = 1'b0; step;
   endtask

   task automatic test_go_trigger;
      n_cmp++; if (bus.trig_o !== 1'b0) begin n_fail++;
         $display("FAIL trig_before_go: got %b expected 0", bus.trig_o); end
      bus.go = 1'b1; step; bus.go = 1'b0;
      n_cmp++; if (bus.trig_o !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin n_fail++;
         $display("FAIL trig_cycle1: got trig %b busy %b done %b expected 1 1 0", bus.trig_o, bus.busy, bus.done); end
      n_cmp++; if (bus.ball_count !== '0 || bus.trace !== '0) begin n_fail++;
         $display("FAIL go_clear: got cnt %0d trace %h expected 0 0", bus.ball_count, bus.trace); end
      step;
      n_cmp++; if (bus.trig_o !== 1'b0 || bus.busy !== 1'b1) begin n_fail++;
         $display("FAIL trig_one_cycle: got trig %b busy %b expected 0 1", bus.trig_o, bus.busy); end
      bus.abort = 1'b1; step; bus.abort = 1'b0;
   endtask

   task automatic test_colours;
      clear_arrays;
      for (int i = 0; i < 4; i++) rel_a[1 + i] = 1'b1;
      col_a[1] = COLOUR_BLUE; col_a[2] = COLOUR_RED; col_a[3] = COLOUR_RED; col_a[4] = COLOUR_BLUE;
      for (int i = 5; i < 9; i++) st_a[i] = 1'b1;
      drive_run(20);
      n_cmp++; if (obs_done !== 9) begin n_fail++;
         $display("FAIL colours_done_cycle: got %0d expected 9", obs_done); end
      n_cmp++; if (obs_trace !== 16'h0006 || obs_cnt !== CW'(4)) begin n_fail++;
         $display("FAIL colours_trace: got trace %h cnt %0d expected 0006 4", obs_trace, obs_cnt); end
      n_cmp++; if (obs_ovf !== 1'b0 || obs_ab !== 1'b0 || obs_to !== 1'b0) begin n_fail++;
         $display("FAIL colours_flags: got %b%b%b expected 000", obs_ovf, obs_ab, obs_to); end
   endtask

   task automatic test_resettle;
      clear_arrays;
      st_a[1] = 1'b1; st_a[2] = 1'b1; st_a[3] = 1'b1;
      rel_a[3] = 1'b1; col_a[3] = COLOUR_RED;
      for (int i = 4; i < 8; i++) st_a[i] = 1'b1;
      drive_run(20);
      n_cmp++; if (obs_done !== 8) begin n_fail++;
         $display("FAIL resettle_done_cycle: got %0d expected 8", obs_done); end
      n_cmp++; if (obs_cnt !== CW'(1) || obs_trace !== 16'h0001) begin n_fail++;
         $display("FAIL resettle_trace: got cnt %0d trace %h expected 1 0001", obs_cnt, obs_trace); end
   endtask

   task automatic test_overflow;
      clear_arrays;
      for (int i = 0; i < 17; i++) begin rel_a[i] = 1'b1; col_a[i] = COLOUR_RED; end
      drive_run(30);
      n_cmp++; if (obs_done !== 16) begin n_fail++;
         $display("FAIL overflow_done_cycle: got %0d expected 16", obs_done); end
      n_cmp++; if (obs_trace !== 16'hFFFF || obs_cnt !== CW'(16) || obs_ovf !== 1'b1) begin n_fail++;
         $display("FAIL overflow_state: got trace %h cnt %0d ovf %b expected FFFF 16 1", obs_trace, obs_cnt, obs_ovf); end
   endtask

   task automatic test_abort;
      clear_arrays;
      rel_a[1] = 1'b1; col_a[1] = COLOUR_BLUE;
      rel_a[2] = 1'b1; col_a[2] = COLOUR_RED;
      rel_a[3] = 1'b1; col_a[3] = COLOUR_RED; ab_a[3] = 1'b1;
      drive_run(20);
      n_cmp++; if (obs_done !== 3 || obs_ab !== 1'b1) begin n_fail++;
         $display("FAIL abort_done: got cycle %0d aborted %b expected 3 1", obs_done, obs_ab); end
      n_cmp++; if (obs_cnt !== CW'(3) || obs_trace !== 16'h0006) begin n_fail++;
         $display("FAIL abort_trace: got cnt %0d trace %h expected 3 0006", obs_cnt, obs_trace); end
      bus.abort = 1'b1; step; bus.abort = 1'b0;
      n_cmp++; if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ball_count !== CW'(3)) begin n_fail++;
         $display("FAIL abort_in_done: got done %b busy %b cnt %0d expected 1 0 3", bus.done, bus.busy, bus.ball_count); end
      bus.go = 1'b1; bus.abort = 1'b1; step; idle_inputs;
      n_cmp++; if (bus.trig_o !== 1'b1 || bus.aborted !== 1'b0 || bus.done !== 1'b0) begin n_fail++;
         $display("FAIL go_beats_abort: got trig %b aborted %b done %b expected 1 0 0", bus.trig_o, bus.aborted, bus.done); end
      n_cmp++; if (bus.ball_count !== '0 || bus.trace !== '0 || bus.overflow !== 1'b0) begin n_fail++;
         $display("FAIL rego_clear: got cnt %0d trace %h ovf %b expected 0 0 0", bus.ball_count, bus.trace, bus.overflow); end
      bus.abort = 1'b1; step; bus.abort = 1'b0;
   endtask

   task automatic test_reset_midrun;
      bus.go = 1'b1; step; bus.go = 1'b0;
      bus.rel_i = 1'b1; bus.colour_i = COLOUR_RED; step; step;
      bus.rel_i = 1'b0; rst = 1'b1; step;
      n_cmp++; if ({bus.trig_o, bus.busy, bus.done} !== 3'b000 || bus.trace !== '0 || bus.ball_count !== '0) begin n_fail++;
         $display("FAIL reset_midrun: got ctl %b trace %h cnt %0d expected 000 0 0",
                  {bus.trig_o, bus.busy, bus.done}, bus.trace, bus.ball_count); end
      rst = 1'b0; step;
   endtask

   task automatic test_watchdog;
`ifdef TUMBLE_WDOG_EN
      clear_arrays;
      drive_run(TMO + 10);
      n_cmp++; if (obs_done !== TMO - 1 || obs_to !== 1'b1) begin n_fail++;
         $display("FAIL wdog_expire: got cycle %0d timed_out %b expected %0d 1", obs_done, obs_to, TMO - 1); end
`else
      int low;
      low = 0;
      bus.go = 1'b1; step; bus.go = 1'b0;
      for (int i = 0; i < 100; i++) begin
         step;
         if (bus.busy !== 1'b1 || bus.timed_out !== 1'b0) low++;
      end
      n_cmp++; if (low !== 0) begin n_fail++;
         $display("FAIL no_wdog_busy: got %0d non-busy cycles expected 0", low); end
      bus.abort = 1'b1; step; bus.abort = 1'b0;
      n_cmp++; if (bus.done !== 1'b1 || bus.timed_out !== 1'b0) begin n_fail++;
         $display("FAIL no_wdog_abort: got done %b timed_out %b expected 1 0", bus.done, bus.timed_out); end
`endif
   endtask

   task automatic test_random;
      int e, cnt, n, rel_mod;
      logic [MAXB-1:0] tr;
      bit ovf, ab, to;
      for (int it = 0; it < 10; it++) begin
         clear_arrays;
         n = 60 + $urandom_range(0, 30);
         rel_mod = 2 + $urandom_range(0, 4);
         for (int i = 0; i < n - 6; i++) begin
            rel_a[i] = ($urandom_range(0, rel_mod - 1) == 0);
            col_a[i] = $urandom_range(0, 1);
            st_a[i]  = ($urandom_range(0, 2) != 0);
            ab_a[i]  = ($urandom_range(0, 149) == 0);
         end
         for (int i = n - 6; i < n; i++) st_a[i] = 1'b1;
         model_run(n, e, tr, cnt, ovf, ab, to);
         drive_run(n);
         n_cmp++; if (obs_done !== e) begin n_fail++;
            $display("FAIL rand%0d_done_cycle: got %0d expected %0d", it, obs_done, e); end
         n_cmp++; if (obs_trace !== tr || int'(obs_cnt) !== cnt) begin n_fail++;
            $display("FAIL rand%0d_trace: got %h/%0d expected %h/%0d", it, obs_trace, obs_cnt, tr, cnt); end
         n_cmp++; if ({obs_ovf, obs_ab, obs_to} !== {ovf, ab, to}) begin n_fail++;
            $display("FAIL rand%0d_flags: got %b%b%b expected %b%b%b", it, obs_ovf, obs_ab, obs_to, ovf, ab, to); end
      end
   endtask

   initial begin
      test_reset;
      test_go_trigger;
      test_colours;
      test_resettle;
      test_overflow;
      test_abort;
      test_reset_midrun;
      test_watchdog;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
